gt_tx_bringup_ctrl: RTL and testbench

GT_TX_BRINGUP_CTRL -- requirements
Module: gt_tx_bringup_ctrl

---
 rtl/gt_tx_bringup_ctrl.sv | 144 ++++++++++++++
 tb/tb_gt_tx_bringup_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gt_tx_bringup_ctrl.sv
// GT TX bring-up sequencer: power-good wait, reset pulse, reset-done wait, stability dwell, retry/fail.
// Latency: status inputs pass a 2-flop synchronizer; all outputs registered. Backpressure: none, level-driven by enable.
module gt_tx_bringup_ctrl #(
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 100000,
  parameter int STABLE_CYCLES      = 1024,
  parameter int MAX_RETRY          = 3,
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
  input  logic          init_clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          force_reinit,
  input  logic          gt_powergood,
  input  logic          tx_resetdone,
  output logic          gt_reset,
  output logic          link_up,
  output logic          link_fail,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   PULSE_LAST = 32'(RESET_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R      = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PWR  = 3'd1,
    S_RST_PULSE = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STABLE    = 3'd4,
    S_LINK_UP   = 3'd5,
    S_RETRY     = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          gt_reset_q, gt_reset_d;
  logic          pg_meta_q, pg_s_q;
  logic          rd_meta_q, rd_s_q;
  logic          both_ok;

  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      gt_reset_q <= 1'b1;
      pg_meta_q  <= 1'b0;
      pg_s_q     <= 1'b0;
      rd_meta_q  <= 1'b0;
      rd_s_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      gt_reset_q <= gt_reset_d;
      pg_meta_q  <= gt_powergood;
      pg_s_q     <= pg_meta_q;
      rd_meta_q  <= tx_resetdone;
      rd_s_q     <= rd_meta_q;
    end
  end

  assign both_ok = pg_s_q & rd_s_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_PWR;
      end
      S_WAIT_PWR: begin
        if (pg_s_q)                state_d = S_RST_PULSE;
        else if (timer_q >= TO_LAST) state_d = S_RETRY;
      end
      S_RST_PULSE: begin
        if (timer_q >= PULSE_LAST) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (rd_s_q)                state_d = S_STABLE;
        else if (timer_q >= TO_LAST) state_d = S_RETRY;
      end
      S_STABLE: begin
        if (!both_ok)                 state_d = S_RETRY;
        else if (stable_q >= STAB_LAST) state_d = S_LINK_UP;
      end
      S_LINK_UP: begin
        // A status drop wins over a concurrent re-init request.
        if (!both_ok) begin
          state_d = S_RETRY;
        end else if (force_reinit) begin
          state_d = S_RST_PULSE;
          retry_d = '0;
        end
      end
      S_RETRY: begin
        if (retry_q >= MAX_R) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_WAIT_PWR;
          retry_d = retry_q + 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_LINK_UP) retry_d = '0;

    if (!enable) begin
      state_d = S_IDLE;
      retry_d = '0;
    end

    if (state_d != state_q) timer_d = '0;
    else if (&timer_q)      timer_d = timer_q;
    else                    timer_d = timer_q + 32'd1;

    if (state_q == S_STABLE && both_ok) stable_d = stable_q + 1'b1;
    else                                stable_d = '0;

    gt_reset_d = !(state_d inside {S_WAIT_DONE, S_STABLE, S_LINK_UP});
  end

  assign gt_reset  = gt_reset_q;
  assign link_up   = (state_q == S_LINK_UP);
  assign link_fail = (state_q == S_FAIL);
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_gt_tx_bringup_ctrl.sv
// Directed bench for gt_tx_bringup_ctrl: nominal bring-up, forced re-init, link drop, glitch, async reset, retry exhaustion.
module tb_gt_tx_bringup_ctrl;

  localparam int ST_IDLE = 0, ST_WP = 1, ST_RST = 2, ST_WD = 3;
  localparam int ST_STB = 4, ST_UP = 5, ST_RETRY = 6, ST_FAIL = 7;

  logic       init_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       force_reinit;
  logic       pg;
  logic       rd;
  logic       gt_reset;
  logic       link_up;
  logic       link_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int n;

  gt_tx_bringup_ctrl #(
    .RESET_PULSE_CYCLES(16),
    .TIMEOUT_CYCLES(1000),
    .STABLE_CYCLES(64),
    .MAX_RETRY(3)
  ) dut (
    .init_clk    (init_clk),
    .rst         (rst),
    .enable      (enable),
    .force_reinit(force_reinit),
    .gt_powergood(pg),
    .tx_resetdone(rd),
    .gt_reset    (gt_reset),
    .link_up     (link_up),
    .link_fail   (link_fail),
    .retry_cnt   (retry_cnt),
    .state_o     (state_o)
  );

  always #5 init_clk = ~init_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge init_clk);
    #1;
  endtask

  // Counts cycles spent in RST_PULSE with gt_reset high; exits on the first non-pulse cycle.
  task automatic measure_pulse(output int len);
    int guard;
    len = 0;
    guard = 0;
    while (state_o == 3'(ST_RST) && guard < 100) begin
      if (gt_reset) len++;
      guard++;
      tick(1);
    end
  endtask

  task automatic wait_state(input int s, input int limit, input string tag);
    int k;
    k = 0;
    while (32'(state_o) != s && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 32'(state_o), s);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; force_reinit = 1'b0; pg = 1'b0; rd = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_state",     32'(state_o),   ST_IDLE);
    check("rst_gt_reset",  32'(gt_reset),  1);
    check("rst_link_up",   32'(link_up),   0);
    check("rst_link_fail", 32'(link_fail), 0);
    check("rst_retry",     32'(retry_cnt), 0);
    tick(3);
    rst = 1'b0;
    tick(4);
    check("idle_hold_disabled", 32'(state_o), ST_IDLE);

    // Nominal bring-up
    pg = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(1);
    check("a_wait_pwr", 32'(state_o), ST_WP);
    tick(1);
    check("a_rst_pulse", 32'(state_o), ST_RST);
    measure_pulse(n);
    check("a_pulse_len", 32'(n), 16);
    check("a_wait_done", 32'(state_o), ST_WD);
    check("a_gt_reset_low", 32'(gt_reset), 0);
    tick(50);
    check("a_still_wait_done", 32'(state_o), ST_WD);
    rd = 1'b1;
    tick(3);
    check("a_stable", 32'(state_o), ST_STB);
    tick(63);
    check("a_no_link_early", 32'(link_up), 0);
    tick(1);
    check("a_link_up", 32'(link_up), 1);
    check("a_state_up", 32'(state_o), ST_UP);
    check("a_retry0", 32'(retry_cnt), 0);

    // Forced re-init from LINK_UP, then a request in WAIT_DONE that must be ignored
    force_reinit = 1'b1;
    tick(1);
    force_reinit = 1'b0;
    check("f_rst_pulse", 32'(state_o), ST_RST);
    check("f_retry0", 32'(retry_cnt), 0);
    measure_pulse(n);
    check("f_pulse_len", 32'(n), 16);
    check("f_wait_done", 32'(state_o), ST_WD);
    force_reinit = 1'b1;
    tick(1);
    force_reinit = 1'b0;
    check("f_ignored_in_wd", 32'(state_o), ST_STB);
    tick(63);
    check("f_stable_hold", 32'(state_o), ST_STB);
    tick(1);
    check("f_link_up", 32'(link_up), 1);

    // One-cycle reset-done drop in LINK_UP
    rd = 1'b0;
    tick(1);
    rd = 1'b1;
    tick(1);
    check("d_still_up", 32'(state_o), ST_UP);
    tick(1);
    check("d_retry_state", 32'(state_o), ST_RETRY);
    check("d_retry_gt_reset", 32'(gt_reset), 1);
    tick(1);
    check("d_wait_pwr", 32'(state_o), ST_WP);
    check("d_retry1", 32'(retry_cnt), 1);
    tick(1);
    check("d_rst_pulse", 32'(state_o), ST_RST);
    tick(16);
    check("d_wait_done", 32'(state_o), ST_WD);
    tick(1);
    check("d_stable", 32'(state_o), ST_STB);
    tick(64);
    check("d_relock", 32'(state_o), ST_UP);
    check("d_retry_cleared", 32'(retry_cnt), 0);

    // Power-good glitch during STABLE
    force_reinit = 1'b1;
    tick(1);
    force_reinit = 1'b0;
    tick(17);
    check("g_stable", 32'(state_o), ST_STB);
    tick(10);
    check("g_count10", 32'(dut.stable_q), 10);
    pg = 1'b0;
    tick(1);
    pg = 1'b1;
    tick(1);
    check("g_count12", 32'(dut.stable_q), 12);
    tick(1);
    check("g_retry", 32'(state_o), ST_RETRY);
    check("g_count_clear", 32'(dut.stable_q), 0);
    tick(1);
    check("g_retry1", 32'(retry_cnt), 1);
    tick(1);
    check("g_rst_pulse", 32'(state_o), ST_RST);
    tick(5);

    // Asynchronous reset mid-RST_PULSE
    #2 rst = 1'b1;
    #1;
    check("r1_state", 32'(state_o), ST_IDLE);
    check("r1_retry", 32'(retry_cnt), 0);
    check("r1_gt_reset", 32'(gt_reset), 1);
    check("r1_timer", dut.timer_q, 0);
    check("r1_pg_sync", 32'(dut.pg_s_q), 0);
    tick(2);
    rst = 1'b0;

    // Asynchronous reset mid-STABLE
    wait_state(ST_STB, 100, "r2_reach_stable");
    tick(20);
    check("r2_count20", 32'(dut.stable_q), 20);
    check("r2_gt_reset_low", 32'(gt_reset), 0);
    #2 rst = 1'b1;
    #1;
    check("r2_state", 32'(state_o), ST_IDLE);
    check("r2_gt_reset", 32'(gt_reset), 1);
    check("r2_stable_cnt", 32'(dut.stable_q), 0);
    check("r2_rd_sync", 32'(dut.rd_s_q), 0);
    check("r2_link_up", 32'(link_up), 0);
    tick(2);

    // Reset-done never arrives: three retries then FAIL
    rd = 1'b0;
    rst = 1'b0;
    tick(1);
    check("x_wait_pwr", 32'(state_o), ST_WP);
    tick(1018);
    check("x_first_retry", 32'(state_o), ST_RETRY);
    check("x_first_retry_cnt", 32'(retry_cnt), 0);
    tick(1);
    check("x_retry1", 32'(retry_cnt), 1);
    tick(3053);
    check("x_last_retry", 32'(state_o), ST_RETRY);
    check("x_retry3", 32'(retry_cnt), 3);
    tick(1);
    check("x_fail", 32'(state_o), ST_FAIL);
    check("x_link_fail", 32'(link_fail), 1);
    check("x_gt_reset", 32'(gt_reset), 1);
    check("x_fail_retry", 32'(retry_cnt), 3);
    force_reinit = 1'b1;
    tick(1);
    force_reinit = 1'b0;
    tick(4);
    check("x_fail_sticky", 32'(state_o), ST_FAIL);
    enable = 1'b0;
    tick(1);
    check("x_idle", 32'(state_o), ST_IDLE);
    check("x_idle_retry", 32'(retry_cnt), 0);
    check("x_idle_link_fail", 32'(link_fail), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
